ram_sp_arb_be: RTL and testbench

//   Parametrised single-port RAM with column write mask, write/read arbitration and a one-entry

---
 rtl/ram_sp_arb_be.sv | 111 +++++++++++
 tb/tb_ram_sp_arb_be.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_arb_be.sv
// Single-port RAM with column write mask, write-over-read arbitration and a one-entry
// pending-read buffer so a reader blocked by a write is served in the next write gap.
module ram_sp_arb_be #(
    parameter int ADR_WD  = 9,
    parameter int DEP     = 384,
    parameter int DAT_WD  = 32,
    parameter int COL_WD  = 8,
    parameter int OUT_REG = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_ena_i,
    input  logic [ADR_WD-1:0]        wr_adr_i,
    input  logic [DAT_WD/COL_WD-1:0] wr_msk_i,
    input  logic [DAT_WD-1:0]        wr_dat_i,
    input  logic                     rd_ena_i,
    input  logic [ADR_WD-1:0]        rd_adr_i,
    output logic                     rd_rdy_o,
    output logic                     rd_vld_o,
    output logic [DAT_WD-1:0]        rd_dat_o
);

    localparam int COL_NUM = DAT_WD / COL_WD;
    localparam logic [ADR_WD:0] DEP_W = (ADR_WD + 1)'(DEP);

    if (((DAT_WD % COL_WD) != 0) || (DEP > 2 ** ADR_WD)) begin : g_param_chk
        $error("ram_sp_arb_be: DAT_WD must be a multiple of COL_WD and DEP must fit in ADR_WD");
    end

    logic [DAT_WD-1:0] mem [DEP];

    logic              pend_vld;
    logic [ADR_WD-1:0] pend_adr;
    logic              rd_accept;
    logic              rd_issue;
    logic [ADR_WD-1:0] issue_adr;
    logic              wr_in_range;
    logic              issue_in_range;
    logic              s1_vld;
    logic [DAT_WD-1:0] s1_dat;

    assign rd_rdy_o  = !pend_vld;
    assign rd_accept = rd_ena_i && rd_rdy_o;

    // The write always owns the port; a waiting pending read beats a fresh request.
    always_comb begin
        rd_issue       = !wr_ena_i && (pend_vld || rd_accept);
        issue_adr      = pend_vld ? pend_adr : rd_adr_i;
        wr_in_range    = {1'b0, wr_adr_i} < DEP_W;
        issue_in_range = {1'b0, issue_adr} < DEP_W;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_vld <= 1'b0;
            pend_adr <= '0;
        end else if (wr_ena_i && rd_accept) begin
            pend_vld <= 1'b1;
            pend_adr <= rd_adr_i;
        end else if (rd_issue && pend_vld) begin
            pend_vld <= 1'b0;
        end
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ena_i && wr_in_range) begin
            for (int c = 0; c < COL_NUM; c++) begin
                if (wr_msk_i[c]) begin
                    mem[wr_adr_i][c*COL_WD +: COL_WD] <= wr_dat_i[c*COL_WD +: COL_WD];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= rd_issue;
            if (rd_issue) begin
                s1_dat <= issue_in_range ? mem[issue_adr] : '0;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic              s2_vld;
        logic [DAT_WD-1:0] s2_dat;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                s2_vld <= 1'b0;
                s2_dat <= '0;
            end else begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_dat <= s1_dat;
                end
            end
        end

        assign rd_vld_o = s2_vld;
        assign rd_dat_o = s2_dat;
    end else begin : g_no_out_reg
        assign rd_vld_o = s1_vld;
        assign rd_dat_o = s1_dat;
    end

endmodule

// File: tb/tb_ram_sp_arb_be.sv
// Bench for ram_sp_arb_be: one instance without and one with the output register, driven
// from a shared vector table; read results are matched against a scoreboard queue per instance.
module tb_ram_sp_arb_be;

    typedef struct {
        logic        wr_ena;
        logic [8:0]  wr_adr;
        logic [3:0]  wr_msk;
        logic [31:0] wr_dat;
        logic        rd_ena;
        logic [8:0]  rd_adr;
        logic [31:0] exp_dat;
        logic        exp_rdy;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        wr_ena = 1'b0;
    logic [8:0]  wr_adr = '0;
    logic [3:0]  wr_msk = '0;
    logic [31:0] wr_dat = '0;
    logic        rd_ena = 1'b0;
    logic [8:0]  rd_adr = '0;
    logic        rd_rdy0, rd_vld0, rd_rdy1, rd_vld1;
    logic [31:0] rd_dat0, rd_dat1;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q [2][$];
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_dat = '0;
    vec_t        vecs [$];

    ram_sp_arb_be #(.OUT_REG(0)) dut0 (
        .clk(clk), .rstn(rstn),
        .wr_ena_i(wr_ena), .wr_adr_i(wr_adr), .wr_msk_i(wr_msk), .wr_dat_i(wr_dat),
        .rd_ena_i(rd_ena), .rd_adr_i(rd_adr),
        .rd_rdy_o(rd_rdy0), .rd_vld_o(rd_vld0), .rd_dat_o(rd_dat0)
    );

    ram_sp_arb_be #(.OUT_REG(1)) dut1 (
        .clk(clk), .rstn(rstn),
        .wr_ena_i(wr_ena), .wr_adr_i(wr_adr), .wr_msk_i(wr_msk), .wr_dat_i(wr_dat),
        .rd_ena_i(rd_ena), .rd_adr_i(rd_adr),
        .rd_rdy_o(rd_rdy1), .rd_vld_o(rd_vld1), .rd_dat_o(rd_dat1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int k, input logic [31:0] got,
                                input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, k, got, exp, cyc);
    endtask

    function automatic vec_t mk(input logic we, input logic [8:0] wa, input logic [3:0] wm,
                                input logic [31:0] wd, input logic re, input logic [8:0] ra,
                                input logic [31:0] ed, input logic er);
        vec_t v;
        v.wr_ena = we; v.wr_adr = wa; v.wr_msk = wm; v.wr_dat = wd;
        v.rd_ena = re; v.rd_adr = ra; v.exp_dat = ed; v.exp_rdy = er;
        return v;
    endfunction

    task automatic push_exp(input logic [31:0] dat, input int n);
        exp_t e;
        e.dat = dat;
        for (int k = 0; k < 2; k++) begin
            e.due = n + 1 + k;
            exp_q[k].push_back(e);
        end
    endtask

    // Drive one cycle of stimulus; the bench's own arbitration model decides when a read issues.
    task automatic apply_stimulus(input vec_t v, input logic chk_rdy);
        logic accept;
        @(posedge clk);
        #1;
        wr_ena = v.wr_ena; wr_adr = v.wr_adr; wr_msk = v.wr_msk; wr_dat = v.wr_dat;
        rd_ena = v.rd_ena; rd_adr = v.rd_adr;
        accept = v.rd_ena && !m_pend;
        if (!v.wr_ena && m_pend) begin
            push_exp(m_pend_dat, cyc);
            m_pend = 1'b0;
        end else if (!v.wr_ena && accept) begin
            push_exp(v.exp_dat, cyc);
        end
        if (v.wr_ena && accept) begin
            m_pend = 1'b1;
            m_pend_dat = v.exp_dat;
        end
        #1;
        if (chk_rdy) begin
            check_output("rd_rdy", 0, {31'd0, rd_rdy0}, {31'd0, v.exp_rdy});
            check_output("rd_rdy", 1, {31'd0, rd_rdy1}, {31'd0, v.exp_rdy});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    endtask

    task automatic check_port(input int k, input logic vld, input logic [31:0] dat);
        exp_t e;
        if (vld) begin
            if (exp_q[k].size() == 0) begin
                n_checks++;
                $display("[TB] FAIL rd_vld dut%0d: got unexpected pulse data %h expected none (cycle %0d)",
                         k, dat, cyc);
            end else begin
                e = exp_q[k].pop_front();
                check_output("rd_dat", k, dat, e.dat);
                check_output("rd_latency", k, cyc, e.due);
            end
        end else if (exp_q[k].size() != 0 && exp_q[k][0].due <= cyc) begin
            e = exp_q[k].pop_front();
            n_checks++;
            $display("[TB] FAIL rd_vld dut%0d: got no pulse expected data %h at cycle %0d", k, e.dat, e.due);
        end
    endtask

    always @(negedge clk) begin
        check_port(0, rd_vld0, rd_dat0);
        check_port(1, rd_vld1, rd_dat1);
    end

    initial begin
        $display("[TB] start");
        #1 rstn = 1'b0;
        #10;
        check_output("reset_rdy", 0, {31'd0, rd_rdy0}, 32'd1);
        check_output("reset_rdy", 1, {31'd0, rd_rdy1}, 32'd1);
        check_output("reset_vld", 0, {31'd0, rd_vld0}, 32'd0);
        check_output("reset_vld", 1, {31'd0, rd_vld1}, 32'd0);
        check_output("reset_dat", 0, rd_dat0, 32'd0);
        check_output("reset_dat", 1, rd_dat1, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        //           we wadr wmsk   wdat          re radr  exp_dat       rdy
        vecs.push_back(mk(1, 5,   4'hF, 32'h11223344, 0, 0,   32'h0,        1));
        vecs.push_back(mk(0, 0,   4'h0, 32'h0,        1, 5,   32'h11223344, 1));
        vecs.push_back(mk(1, 5,   4'h5, 32'hAABBCCDD, 0, 0,   32'h0,        1));
        vecs.push_back(mk(0, 0,   4'h0, 32'h0,        1, 5,   32'h11BB33DD, 1));
        vecs.push_back(mk(1, 7,   4'hF, 32'hDEADBEEF, 1, 5,   32'h11BB33DD, 1));
        vecs.push_back(mk(0, 0,   4'h0, 32'h0,        0, 0,   32'h0,        0));
        vecs.push_back(mk(0, 0,   4'h0, 32'h0,        0, 0,   32'h0,        1));
        vecs.push_back(mk(1, 8,   4'hF, 32'h01020304, 1, 7,   32'hDEADBEEF, 1));
        vecs.push_back(mk(1, 9,   4'hF, 32'h0A0B0C0D, 1, 5,   32'h0,        0));
        vecs.push_back(mk(1, 10,  4'hF, 32'h55667788, 1, 8,   32'h0,        0));
        vecs.push_back(mk(1, 9,   4'h0, 32'h99AABBCC, 0, 0,   32'h0,        0));
        vecs.push_back(mk(0, 0,   4'h0, 32'h0,        0, 0,   32'h0,        0));
        vecs.push_back(mk(0, 0,   4'h0, 32'h0,        0, 0,   32'h0,        1));
        vecs.push_back(mk(0, 0,   4'h0, 32'h0,        1, 8,   32'h01020304, 1));
        vecs.push_back(mk(0, 0,   4'h0, 32'h0,        1, 9,   32'h0A0B0C0D, 1));
        vecs.push_back(mk(0, 0,   4'h0, 32'h0,        1, 10,  32'h55667788, 1));
        vecs.push_back(mk(0, 0,   4'h0, 32'h0,        1, 7,   32'hDEADBEEF, 1));
        vecs.push_back(mk(1, 5,   4'hA, 32'h00FF00FF, 0, 0,   32'h0,        1));
        vecs.push_back(mk(0, 0,   4'h0, 32'h0,        1, 5,   32'h00BB00DD, 1));
        vecs.push_back(mk(1, 400, 4'hF, 32'hFFFFFFFF, 0, 0,   32'h0,        1));
        vecs.push_back(mk(0, 0,   4'h0, 32'h0,        1, 400, 32'h0,        1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 9'(i), 4'hF, 32'hC0DE0000 + i, 0, 0, 32'h0, 1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 4'h0, 32'h0, 1, 9'(i), 32'hC0DE0000 + i, 1));

        foreach (vecs[i]) apply_stimulus(vecs[i], 1'b1);
        idle(4);
        check_output("hold_dat", 0, rd_dat0, 32'hC0DE0003);
        check_output("hold_dat", 1, rd_dat1, 32'hC0DE0003);

        // Reset with one read in flight and one pending.
        apply_stimulus(mk(0, 0,  4'h0, 32'h0,        1, 1, 32'hC0DE0001, 1), 1'b1);
        apply_stimulus(mk(1, 20, 4'hF, 32'h12345678, 1, 0, 32'hC0DE0000, 1), 1'b1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        wr_ena = 1'b0; rd_ena = 1'b0;
        #1;
        exp_q[0].delete();
        exp_q[1].delete();
        m_pend = 1'b0;
        check_output("async_rst_rdy", 0, {31'd0, rd_rdy0}, 32'd1);
        check_output("async_rst_rdy", 1, {31'd0, rd_rdy1}, 32'd1);
        check_output("async_rst_vld", 1, {31'd0, rd_vld1}, 32'd0);
        check_output("async_rst_dat", 0, rd_dat0, 32'd0);
        check_output("async_rst_dat", 1, rd_dat1, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        idle(4);
        apply_stimulus(mk(0, 0, 4'h0, 32'h0, 1, 400, 32'h0, 1), 1'b1);
        idle(4);
        check_output("q_empty", 0, exp_q[0].size(), 32'd0);
        check_output("q_empty", 1, exp_q[1].size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
